// File: rtl/instr_scheduler.sv
// Instruction FIFO sequencer: gates save/delete/clear while idle, replays FIFO entries to the displays.
// Latency: request strobes one cycle after the request; exec_req to first show_en is 3 cycles.
// Backpressure: requests while busy (or refused while idle) give a one-cycle rejected pulse, no FIFO strobe.
module instr_scheduler #(
  parameter int DATA_W       = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 12500000,
  parameter int CNT_W        = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              save_req,
  input  logic              del_req,
  input  logic              exec_req,
  input  logic              abort_req,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_we,
  output logic              fifo_re,
  output logic              fifo_del,
  output logic              fifo_clr,
  output logic [DATA_W-1:0] active_instr,
  output logic              show_en,
  output logic              busy,
  output logic [3:0]        step_cnt,
  output logic              done,
  output logic              rejected
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    DWELL  = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP    = (GAP_CYCLES > 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer;
  logic             timer_zero;
  logic             any_req;

  logic we_nxt, re_nxt, del_nxt, clr_nxt, done_nxt, rej_nxt;

  assign timer_zero = (timer == '0);
  assign any_req    = save_req | del_req | exec_req;
  assign busy       = (state != IDLE);
  assign show_en    = (state == DWELL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort always wins and returns to IDLE; otherwise the timed sequence
  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (exec_req && !fifo_empty) state_nxt = FETCH;
        FETCH:  state_nxt = LOAD;
        LOAD:   state_nxt = DWELL;
        DWELL: begin
          if (timer_zero) begin
            if (fifo_empty)    state_nxt = FINISH;
            else if (HAS_GAP)  state_nxt = GAP;
            else               state_nxt = FETCH;
          end
        end
        // An empty FIFO at the end of a gap ends the run rather than popping nothing
        GAP:    if (timer_zero) state_nxt = fifo_empty ? FINISH : FETCH;
        FINISH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Strobe decode: next-cycle values of the single-cycle, mutually exclusive strobes
  always_comb begin
    we_nxt   = 1'b0;
    re_nxt   = 1'b0;
    del_nxt  = 1'b0;
    clr_nxt  = 1'b0;
    done_nxt = 1'b0;
    rej_nxt  = 1'b0;
    if (abort_req) begin
      clr_nxt = 1'b1;
    end else begin
      re_nxt   = (state_nxt == FETCH);
      done_nxt = (state_nxt == FINISH);
      if (state == IDLE) begin
        // One action per cycle: exec > save > del, lower ones silently dropped
        if (exec_req) begin
          rej_nxt = fifo_empty;
        end else if (save_req) begin
          we_nxt  = !fifo_full;
          rej_nxt = fifo_full;
        end else if (del_req) begin
          del_nxt = !fifo_empty;
          rej_nxt = fifo_empty;
        end
      end else begin
        // A refusal that would land on a fifo_re or done cycle is not signalled,
        // keeping every strobe exclusive
        rej_nxt = any_req && !re_nxt && !done_nxt;
      end
    end
  end

  // Register the strobes so they leave the block glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_we  <= 1'b0;
      fifo_re  <= 1'b0;
      fifo_del <= 1'b0;
      fifo_clr <= 1'b0;
      done     <= 1'b0;
      rejected <= 1'b0;
    end else begin
      fifo_we  <= we_nxt;
      fifo_re  <= re_nxt;
      fifo_del <= del_nxt;
      fifo_clr <= clr_nxt;
      done     <= done_nxt;
      rejected <= rej_nxt;
    end
  end

  // Dwell/gap timer: loaded on entry, counts down to zero within the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else begin
      case (state)
        LOAD:    timer <= DWELL_LOAD;
        DWELL:   timer <= timer_zero ? GAP_LOAD : timer - 1'b1;
        GAP:     if (!timer_zero) timer <= timer - 1'b1;
        default: timer <= timer;
      endcase
    end
  end

  // Display latch: captures the popped entry, cleared on abort or run end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_instr <= '0;
    end else if (abort_req || state == FINISH) begin
      active_instr <= '0;
    end else if (state == LOAD) begin
      active_instr <= fifo_rdata;
    end
  end

  // Completed-instruction counter: zeroed at run start, saturating at 15, held on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 4'd0;
    end else if (!abort_req) begin
      if (state == IDLE && exec_req && !fifo_empty) begin
        step_cnt <= 4'd0;
      end else if (state == DWELL && timer_zero && step_cnt != 4'd15) begin
        step_cnt <= step_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_scheduler.sv
// Bench for instr_scheduler: table-driven idle decisions, hand-written runs, randomized runs.
// Small dwell/gap so whole runs fit in a few dozen cycles.
// A 4-deep FIFO model in the bench answers the DUT's strobes.
module tb_instr_scheduler;

  localparam int DW    = 8;
  localparam int GP    = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       save_req, del_req, exec_req, abort_req;
  logic       fifo_empty, fifo_full;
  logic [3:0] fifo_rdata;
  logic       fifo_we, fifo_re, fifo_del, fifo_clr;
  logic [3:0] active_instr;
  logic       show_en, busy, done, rejected;
  logic [3:0] step_cnt;

  logic [3:0] sw_data;
  logic [3:0] mem [DEPTH];
  logic [2:0] cnt = 3'd0;
  logic [3:0] dat [16];

  int nvec = 0;
  int nmis = 0;

  instr_scheduler #(.DATA_W(4), .DWELL_CYCLES(DW), .GAP_CYCLES(GP), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .save_req(save_req), .del_req(del_req), .exec_req(exec_req), .abort_req(abort_req),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rdata(fifo_rdata),
    .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_del(fifo_del), .fifo_clr(fifo_clr),
    .active_instr(active_instr), .show_en(show_en), .busy(busy),
    .step_cnt(step_cnt), .done(done), .rejected(rejected)
  );

  always #5 clk = ~clk;

  // FIFO model: acts on the strobes present in the cycle before the edge
  assign fifo_empty = (cnt == 3'd0);
  assign fifo_full  = (cnt == 3'(DEPTH));
  initial fifo_rdata = 4'd0;
  always @(posedge clk) begin
    if (fifo_clr) begin
      cnt <= 3'd0;
    end else if (fifo_we && cnt < 3'(DEPTH)) begin
      mem[cnt[1:0]] <= sw_data;
      cnt <= cnt + 3'd1;
    end else if (fifo_del && cnt > 3'd0) begin
      cnt <= cnt - 3'd1;
    end else if (fifo_re && cnt > 3'd0) begin
      fifo_rdata <= mem[0];
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      cnt <= cnt - 3'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Return to IDLE with an empty FIFO, then push dat[0..n-1]
  task automatic fill(input int n);
    abort_req = 1'b1; cyc(); abort_req = 1'b0; cyc();
    for (int i = 0; i < n; i++) begin
      sw_data = dat[i];
      save_req = 1'b1; cyc(); save_req = 1'b0; cyc();
    end
  endtask

  // Idle request decision from the priority rules: {we, re, del, clr, rej, busy}
  function automatic logic [5:0] idle_ref(input int lvl, input logic ab, ex, sv, dl);
    if (ab)      return 6'b000100;
    else if (ex) return (lvl > 0) ? 6'b010001 : 6'b000010;
    else if (sv) return (lvl < DEPTH) ? 6'b100000 : 6'b000010;
    else if (dl) return (lvl > 0) ? 6'b001000 : 6'b000010;
    return 6'b000000;
  endfunction

  task automatic apply_idle(input string nm, input int lvl, input logic ab, ex, sv, dl,
                            input logic [5:0] exp);
    fill(lvl);
    abort_req = ab; exec_req = ex; save_req = sv; del_req = dl;
    cyc();
    abort_req = 1'b0; exec_req = 1'b0; save_req = 1'b0; del_req = 1'b0;
    chk({nm, ".we"},   fifo_we,  exp[5]);
    chk({nm, ".re"},   fifo_re,  exp[4]);
    chk({nm, ".del"},  fifo_del, exp[3]);
    chk({nm, ".clr"},  fifo_clr, exp[2]);
    chk({nm, ".rej"},  rejected, exp[1]);
    chk({nm, ".busy"}, busy,     exp[0]);
  endtask

  task automatic chk_cycle(input logic re, sh, chka, input logic [3:0] a, input logic dn);
    chk("run.fifo_re", fifo_re, re);
    chk("run.show_en", show_en, sh);
    chk("run.done",    done,    dn);
    if (chka) chk("run.active_instr", active_instr, a);
    cyc();
  endtask

  // Entered in the first FETCH cycle; expected timeline built from dwell/gap counts
  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      chk_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      for (int k = 0; k < DW; k++) chk_cycle(1'b0, 1'b1, 1'b1, dat[i], 1'b0);
      if (i < n - 1)
        for (int k = 0; k < GP; k++) chk_cycle(1'b0, 1'b0, 1'b1, dat[i], 1'b0);
    end
    chk_cycle(1'b0, 1'b0, 1'b1, dat[n-1], 1'b1);
    chk("end.busy", busy, 0);
    chk("end.active_instr", active_instr, 0);
    chk("end.step_cnt", step_cnt, n);
    chk("end.done", done, 0);
  endtask

  typedef struct {
    string      nm;
    int         lvl;
    logic       ab, ex, sv, dl;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{"save_ok",        0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b100000};
    tbl[1]  = '{"save_full",      4, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000010};
    tbl[2]  = '{"del_empty",      0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000010};
    tbl[3]  = '{"del_ok",         2, 1'b0, 1'b0, 1'b0, 1'b1, 6'b001000};
    tbl[4]  = '{"exec_empty",     0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000010};
    tbl[5]  = '{"exec_ok",        2, 1'b0, 1'b1, 1'b0, 1'b0, 6'b010001};
    tbl[6]  = '{"save_exec",      2, 1'b0, 1'b1, 1'b1, 1'b0, 6'b010001};
    tbl[7]  = '{"abort_all",      1, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000100};
    tbl[8]  = '{"save_del_full",  4, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000010};
    tbl[9]  = '{"exec_del_empty", 0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000010};
    tbl[10] = '{"abort_idle",     2, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100};
    tbl[11] = '{"save_del",       2, 1'b0, 1'b0, 1'b1, 1'b1, 6'b100000};

    for (int i = 0; i < 16; i++) dat[i] = 4'(i + 3);
    rst_n = 1'b0; sw_data = 4'd0;
    save_req = 1'b0; del_req = 1'b0; exec_req = 1'b0; abort_req = 1'b0;

    // Reset state
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.show_en", show_en, 0);
    chk("rst.active_instr", active_instr, 0);
    chk("rst.step_cnt", step_cnt, 0);
    chk("rst.strobes", {fifo_we, fifo_re, fifo_del, fifo_clr, done, rejected}, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 12; i++)
      apply_idle(tbl[i].nm, tbl[i].lvl, tbl[i].ab, tbl[i].ex, tbl[i].sv, tbl[i].dl, tbl[i].exp);

    // Full three-instruction run
    dat[0] = 4'h1; dat[1] = 4'h6; dat[2] = 4'hB;
    fill(3);
    exec_req = 1'b1; cyc(); exec_req = 1'b0;
    run_check(3);

    // Abort in the third cycle of the second instruction's dwell
    fill(3);
    exec_req = 1'b1; cyc(); exec_req = 1'b0;
    repeat (15) cyc();
    chk("abort.pre_show", show_en, 1);
    chk("abort.pre_active", active_instr, 4'h6);
    repeat (2) cyc();
    abort_req = 1'b1; cyc(); abort_req = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.clr", fifo_clr, 1);
    chk("abort.show_en", show_en, 0);
    chk("abort.active_instr", active_instr, 0);
    chk("abort.done", done, 0);
    chk("abort.step_cnt", step_cnt, 1);
    cyc();
    chk("abort.clr_single", fifo_clr, 0);
    chk("abort.no_done", done, 0);

    // Save request while displaying
    fill(2);
    exec_req = 1'b1; cyc(); exec_req = 1'b0;
    repeat (3) cyc();
    save_req = 1'b1; sw_data = 4'h5; cyc(); save_req = 1'b0;
    chk("busy_save.rej", rejected, 1);
    chk("busy_save.we", fifo_we, 0);
    chk("busy_save.show_en", show_en, 1);

    // Asynchronous reset in the middle of a gap
    dat[0] = 4'h9; dat[1] = 4'h5;
    fill(2);
    exec_req = 1'b1; cyc(); exec_req = 1'b0;
    repeat (10) cyc();
    chk("gap.show_en", show_en, 0);
    chk("gap.active_instr", active_instr, 4'h9);
    chk("gap.busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.active_instr", active_instr, 0);
    chk("arst.step_cnt", step_cnt, 0);
    chk("arst.show_en", show_en, 0);
    #3 rst_n = 1'b1;
    cyc();
    sw_data = 4'h2;
    save_req = 1'b1; cyc(); save_req = 1'b0;
    chk("arst.save_we", fifo_we, 1);
    chk("arst.save_rej", rejected, 0);

    // Random idle request combinations against the decision rules
    repeat (20) begin
      int lvl;
      logic ab, ex, sv, dl;
      lvl = int'($urandom_range(0, DEPTH));
      ab = 1'($urandom_range(0, 4) == 0);
      ex = 1'($urandom); sv = 1'($urandom); dl = 1'($urandom);
      for (int i = 0; i < DEPTH; i++) dat[i] = 4'($urandom);
      apply_idle("rnd_idle", lvl, ab, ex, sv, dl, idle_ref(lvl, ab, ex, sv, dl));
    end

    // Random full runs
    repeat (5) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) dat[i] = 4'($urandom);
      fill(n);
      exec_req = 1'b1; cyc(); exec_req = 1'b0;
      run_check(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
